// File: rtl/uart_wb_pkg.sv
// Shared command type, host FSM states and UART register map for the Wishbone host.
package uart_wb_pkg;

   localparam logic [2:0] UART_RBR = 3'd0;
   localparam logic [2:0] UART_THR = 3'd0;
   localparam logic [2:0] UART_IER = 3'd1;
   localparam logic [2:0] UART_IIR = 3'd2;
   localparam logic [2:0] UART_FCR = 3'd2;
   localparam logic [2:0] UART_LCR = 3'd3;
   localparam logic [2:0] UART_MCR = 3'd4;
   localparam logic [2:0] UART_LSR = 3'd5;
   localparam logic [2:0] UART_MSR = 3'd6;
   localparam logic [2:0] UART_SCR = 3'd7;

   typedef struct packed {
      logic       we;
      logic [2:0] addr;
      logic [7:0] data;
   } uart_cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } host_state_t;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous command FIFO; push_rdy is registered, so a pop while full frees a slot
// one cycle later. Head entry is visible combinationally from the read pointer.
module uart_cmd_fifo
   import uart_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      push_vld,
   output logic      push_rdy,
   input  uart_cmd_t push_dat,
   input  logic      pop,
   output uart_cmd_t head_dat,
   output logic      empty,
   output logic      empty_nxt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   uart_cmd_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic            do_push, do_pop;

   assign do_push   = push_vld & push_rdy;
   assign do_pop    = pop & ~empty;
   assign empty     = (count == '0);
   assign empty_nxt = (count_nxt == '0);
   assign head_dat  = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         push_rdy <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count_nxt;
         push_rdy <= (count_nxt != CW'(DEPTH));
      end
   end

endmodule

// File: rtl/uart_wb_host.sv
// Wishbone classic master for the UART slave: one bus cycle per buffered command, >=3 edges push->rsp.
// Optional bus timeout under UART_WB_TIMEOUT_EN; rsp_valid holds until rsp_ready, cmd_ready drops when FIFO full.
module uart_wb_host
   import uart_wb_pkg::*;
#(
   parameter int         FIFO_DEPTH     = 4,
   parameter logic [3:0] WB_SEL         = 4'hF,
   parameter int         TIMEOUT_CYCLES = 16
) (
   input  logic       clock,
   input  logic       WB_RST_I,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_we,
   input  logic [2:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_we,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic [2:0] WB_ADDR_O,
   output logic [3:0] WB_SEL_O,
   output logic [7:0] WB_DAT_O,
   input  logic [7:0] WB_DAT_I,
   output logic       WB_WE_O,
   output logic       WB_STB_O,
   output logic       WB_CYC_O,
   input  logic       WB_ACK_I,
   input  logic       INT_I,
   output logic       irq_pending,
   output logic       busy
);

   host_state_t state, state_nxt;
   uart_cmd_t   cmd_dat, head_dat;
   logic        fifo_empty, fifo_empty_nxt, pop;
   logic [2:0]  addr_nxt;
   logic [7:0]  dat_nxt, rsp_dat_nxt;
   logic        we_nxt, cyc_nxt, rsp_vld_nxt, rsp_we_nxt, rsp_err_nxt;
   logic        tmo_hit;

   assign cmd_dat = '{we: cmd_we, addr: cmd_addr, data: cmd_data};

   uart_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
      .clock     (clock),
      .reset     (WB_RST_I),
      .push_vld  (cmd_valid),
      .push_rdy  (cmd_ready),
      .push_dat  (cmd_dat),
      .pop       (pop),
      .head_dat  (head_dat),
      .empty     (fifo_empty),
      .empty_nxt (fifo_empty_nxt)
   );

`ifdef UART_WB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;

   // Fires on the last permitted BUS edge; ACK on that same edge takes priority.
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (WB_RST_I || state != BUS) tmo_cnt <= '0;
      else                          tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      addr_nxt    = WB_ADDR_O;
      dat_nxt     = WB_DAT_O;
      we_nxt      = WB_WE_O;
      cyc_nxt     = WB_CYC_O;
      rsp_vld_nxt = rsp_valid;
      rsp_we_nxt  = rsp_we;
      rsp_dat_nxt = rsp_data;
      rsp_err_nxt = rsp_err;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               addr_nxt  = head_dat.addr;
               dat_nxt   = head_dat.data;
               we_nxt    = head_dat.we;
               cyc_nxt   = 1'b1;
               state_nxt = BUS;
            end
         end
         BUS: begin
            if (WB_ACK_I || tmo_hit) begin
               cyc_nxt     = 1'b0;
               rsp_vld_nxt = 1'b1;
               rsp_we_nxt  = WB_WE_O;
               rsp_dat_nxt = (WB_ACK_I && !WB_WE_O) ? WB_DAT_I : 8'h00;
               rsp_err_nxt = ~WB_ACK_I;
               state_nxt   = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_vld_nxt = 1'b0;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (WB_RST_I) begin
         state       <= IDLE;
         WB_ADDR_O   <= '0;
         WB_DAT_O    <= '0;
         WB_WE_O     <= 1'b0;
         WB_CYC_O    <= 1'b0;
         WB_STB_O    <= 1'b0;
         WB_SEL_O    <= WB_SEL;
         rsp_valid   <= 1'b0;
         rsp_we      <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         irq_pending <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         WB_ADDR_O   <= addr_nxt;
         WB_DAT_O    <= dat_nxt;
         WB_WE_O     <= we_nxt;
         WB_CYC_O    <= cyc_nxt;
         WB_STB_O    <= cyc_nxt;
         WB_SEL_O    <= WB_SEL;
         rsp_valid   <= rsp_vld_nxt;
         rsp_we      <= rsp_we_nxt;
         rsp_data    <= rsp_dat_nxt;
         rsp_err     <= rsp_err_nxt;
         irq_pending <= INT_I;
         busy        <= (state_nxt != IDLE) || !fifo_empty_nxt;
      end
   end

endmodule

// File: tb/tb_uart_wb_host.sv
// Scoreboard bench for uart_wb_host: a slave model checks bus requests, a monitor checks responses.
// Timeout scenario is exercised when UART_WB_TIMEOUT_EN is defined.
module tb_uart_wb_host;
   import uart_wb_pkg::*;

   logic       clock = 1'b0;
   logic       WB_RST_I, cmd_valid, cmd_we, rsp_ready, WB_ACK_I, INT_I;
   logic [2:0] cmd_addr;
   logic [7:0] cmd_data, WB_DAT_I;
   logic       cmd_ready, rsp_valid, rsp_we, rsp_err, WB_WE_O, WB_STB_O, WB_CYC_O;
   logic       irq_pending, busy;
   logic [7:0] rsp_data, WB_DAT_O;
   logic [2:0] WB_ADDR_O;
   logic [3:0] WB_SEL_O;

   typedef struct {
      logic       we;
      logic [7:0] data;
      logic       err;
   } rsp_exp_t;

   rsp_exp_t   rsp_q[$];
   uart_cmd_t  req_q[$];
   int         checks = 0;
   int         failures = 0;
   logic       stall = 1'b0;
   int         ack_delay = 1;
   logic [7:0] slave_mem [8];

   always #5 clock = ~clock;

   uart_wb_host dut (
      .clock(clock), .WB_RST_I(WB_RST_I),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .WB_ADDR_O(WB_ADDR_O), .WB_SEL_O(WB_SEL_O), .WB_DAT_O(WB_DAT_O),
      .WB_DAT_I(WB_DAT_I), .WB_WE_O(WB_WE_O), .WB_STB_O(WB_STB_O),
      .WB_CYC_O(WB_CYC_O), .WB_ACK_I(WB_ACK_I), .INT_I(INT_I),
      .irq_pending(irq_pending), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the handshake edge.
   task automatic push(input logic we, input logic [2:0] addr, input logic [7:0] data,
                       input logic exp_err);
      int budget = 0;
      while (!cmd_ready && budget < 100) begin
         @(posedge clock); #1;
         budget++;
      end
      check("push_ready", cmd_ready, 1);
      if (cmd_ready) begin
         cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
         @(posedge clock);
         req_q.push_back('{we: we, addr: addr, data: data});
         rsp_q.push_back('{we: we, data: (we || exp_err) ? 8'h00 : slave_mem[addr], err: exp_err});
         #1;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int budget = 0;
      while ((rsp_q.size() != 0 || req_q.size() != 0) && budget < 300) begin
         @(posedge clock); #1;
         budget++;
      end
      check("drain_rsp_q", rsp_q.size(), 0);
   endtask

   task automatic wait_rsp_valid();
      int budget = 0;
      @(negedge clock);
      while (!rsp_valid && budget < 100) begin
         @(negedge clock);
         budget++;
      end
      check("rsp_valid_wait", rsp_valid, 1);
   endtask

   // Wishbone slave model: checks each cycle against the request queue, ACKs after ack_delay.
   initial begin
      uart_cmd_t snap;
      logic was_cyc = 1'b0;
      int   wait_cnt = 0;
      WB_ACK_I = 1'b0;
      WB_DAT_I = 8'h00;
      snap = '0;
      forever begin
         @(negedge clock);
         if (WB_CYC_O) begin
            check("wb_stb_eq_cyc", WB_STB_O, 1);
            if (!was_cyc) begin
               wait_cnt = 0;
               check("wb_sel", WB_SEL_O, 4'hF);
               if (req_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL wb_unexpected_cycle addr=%0h required=none", WB_ADDR_O);
               end else begin
                  snap = req_q[0];
                  check("wb_addr", WB_ADDR_O, snap.addr);
                  check("wb_we", WB_WE_O, snap.we);
                  if (snap.we) check("wb_dat_o", WB_DAT_O, snap.data);
               end
            end else begin
               check("wb_hold_addr", WB_ADDR_O, snap.addr);
               check("wb_hold_we", WB_WE_O, snap.we);
            end
            if (stall) WB_ACK_I = 1'b0;
            else begin
               wait_cnt++;
               if (wait_cnt >= ack_delay) begin
                  WB_ACK_I = 1'b1;
                  WB_DAT_I = slave_mem[WB_ADDR_O];
               end else WB_ACK_I = 1'b0;
            end
         end else begin
            WB_ACK_I = 1'b0;
            if (was_cyc && req_q.size() != 0) void'(req_q.pop_front());
         end
         was_cyc = WB_CYC_O;
      end
   end

   // Response monitor: handshake completes on the following posedge.
   initial begin
      rsp_exp_t e;
      forever begin
         @(negedge clock);
         if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected data=%0h required=none", rsp_data);
            end else begin
               e = rsp_q.pop_front();
               check("rsp_we", rsp_we, e.we);
               check("rsp_data", rsp_data, e.data);
               check("rsp_err", rsp_err, e.err);
            end
         end
      end
   end

   initial begin
      slave_mem[0] = 8'h41; slave_mem[1] = 8'h0F; slave_mem[2] = 8'hC1; slave_mem[3] = 8'h5A;
      slave_mem[4] = 8'h0B; slave_mem[5] = 8'h60; slave_mem[6] = 8'hB0; slave_mem[7] = 8'hC3;
      WB_RST_I = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
      rsp_ready = 1'b1; INT_I = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_we", rsp_we, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_wb_addr", WB_ADDR_O, 0);
      check("rst_wb_dat", WB_DAT_O, 0);
      check("rst_wb_we", WB_WE_O, 0);
      check("rst_wb_stb", WB_STB_O, 0);
      check("rst_wb_cyc", WB_CYC_O, 0);
      check("rst_wb_sel", WB_SEL_O, 4'hF);
      check("rst_irq", irq_pending, 0);
      check("rst_busy", busy, 0);
      @(posedge clock); #1;
      WB_RST_I = 1'b0;

      // Minimum latency: push t0, CYC after t1, ACK at t2, rsp_valid after t2.
      ack_delay = 1;
      push(1'b0, UART_SCR, 8'h00, 1'b0);
      @(negedge clock);
      check("lat_cyc_t0", WB_CYC_O, 0);
      check("lat_busy_t0", busy, 1);
      @(negedge clock);
      check("lat_cyc_t1", WB_CYC_O, 1);
      check("lat_rsp_t1", rsp_valid, 0);
      @(negedge clock);
      check("lat_rsp_t2", rsp_valid, 1);
      @(posedge clock); #1;
      wait_drain();

      // LCR write with ACK two cycles after STB; slave drives nonzero DAT_I.
      ack_delay = 2;
      push(1'b1, UART_LCR, 8'h83, 1'b0);
      wait_rsp_valid();
      check("lcr_cyc_dropped", WB_CYC_O, 0);
      check("lcr_stb_dropped", WB_STB_O, 0);
      @(posedge clock); #1;
      wait_drain();

      // LSR read with response held off for 5 cycles.
      ack_delay = 1;
      rsp_ready = 1'b0;
      push(1'b0, UART_LSR, 8'h00, 1'b0);
      wait_rsp_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_data", rsp_data, 8'h60);
         check("hold_busy", busy, 1);
      end
      @(posedge clock); #1;
      rsp_ready = 1'b1;
      wait_drain();

      // Five back-to-back commands with the slave stalled: FIFO fills.
      stall = 1'b1;
      push(1'b1, UART_IER, 8'h05, 1'b0);
      push(1'b0, UART_IIR, 8'h00, 1'b0);
      push(1'b1, UART_MCR, 8'h0B, 1'b0);
      push(1'b0, UART_MSR, 8'h00, 1'b0);
      push(1'b1, UART_SCR, 8'h77, 1'b0);
      check("full_cmd_ready", cmd_ready, 0);
      check("full_cyc", WB_CYC_O, 1);
      check("full_addr", WB_ADDR_O, UART_IER);
      repeat (8) @(posedge clock);
      #1;
      check("stall_cyc_held", WB_CYC_O, 1);
      check("stall_cmd_ready", cmd_ready, 0);
      stall = 1'b0;
      wait_drain();

      // Interrupt line registered with one cycle of delay.
      INT_I = 1'b1;
      @(negedge clock); check("irq_before", irq_pending, 0);
      @(negedge clock); check("irq_rise", irq_pending, 1);
      @(posedge clock); #1;
      INT_I = 1'b0;
      @(negedge clock); check("irq_hold", irq_pending, 1);
      @(negedge clock); check("irq_fall", irq_pending, 0);
      @(posedge clock); #1;

      // Reset during BUS with two commands queued.
      stall = 1'b1;
      push(1'b1, UART_THR, 8'h11, 1'b0);
      push(1'b1, UART_THR, 8'h22, 1'b0);
      push(1'b1, UART_THR, 8'h33, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      check("mid_cyc_before", WB_CYC_O, 1);
      WB_RST_I = 1'b1;
      @(posedge clock); #1;
      WB_RST_I = 1'b0;
      req_q.delete();
      rsp_q.delete();
      check("mid_cyc", WB_CYC_O, 0);
      check("mid_stb", WB_STB_O, 0);
      check("mid_rsp_valid", rsp_valid, 0);
      check("mid_cmd_ready", cmd_ready, 1);
      check("mid_busy", busy, 0);
      stall = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check("mid_cyc_after", WB_CYC_O, 0);
      check("mid_busy_after", busy, 0);

`ifdef UART_WB_TIMEOUT_EN
      begin
         int cyc_cnt = 0;
         stall = 1'b1;
         push(1'b1, UART_THR, 8'h41, 1'b1);
         for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (WB_CYC_O) cyc_cnt++;
         end
         check("tmo_cyc_cycles", cyc_cnt, 16);
         @(posedge clock); #1;
         stall = 1'b0;
         push(1'b0, UART_LSR, 8'h00, 1'b0);
         wait_drain();
      end
`endif

      wait_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
